// File: rtl/frame_dump_pkg.sv
// frame_dump_pkg: shared header bytes and dump FSM states
package frame_dump_pkg;
  localparam logic [7:0] HDR0_BYTE = 8'hA5;
  localparam logic [7:0] HDR1_BYTE = 8'h5A;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, FETCH, LATCH, SEND, CKSUM, FIN} state_t;
endpackage

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 UART transmitter with a valid/ready byte handshake
// Ports: pixclk, reset (sync, active high); data/valid/ready accept one byte when idle; tx is the idle-high line.
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       pixclk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  logic [9:0] shreg;
  logic [3:0] bit_cnt;
  logic [CW-1:0] clk_cnt;
  logic active;
  assign ready = !active;
  assign tx = active ? shreg[0] : 1'b1;
  always_ff @(posedge pixclk)
    if (reset) begin
      active <= 1'b0;
      shreg <= '1;
      bit_cnt <= '0;
      clk_cnt <= '0;
    end else if (!active) begin
      if (valid) begin
        active <= 1'b1;
        shreg <= {1'b1, data, 1'b0};
        bit_cnt <= '0;
        clk_cnt <= '0;
      end
    end else if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
      clk_cnt <= '0;
      shreg <= {1'b1, shreg[9:1]};
      active <= bit_cnt != 4'd9;
      bit_cnt <= bit_cnt == 4'd9 ? 4'd0 : bit_cnt + 4'd1;
    end else
      clk_cnt <= clk_cnt + 1'b1;
endmodule

// File: rtl/frame_uart_dump.sv
// frame_uart_dump: streams a framebuffer over UART as header, pixel bytes and checksum
// Ports: pixclk, reset (sync, active high); start requests a dump; ram_addr/ram_data is the external
// 1-cycle-latency read port; tx is the 8N1 line; busy spans the dump; done pulses once at the end.
module frame_uart_dump
  import frame_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int WORDS = 76800,
  parameter int ADDR_W = 17
) (
  input  logic              pixclk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  state_t state, state_nx;
  logic [31:0] word;
  logic [1:0] byte_idx;
  logic [7:0] cksum, tx_data;
  logic tx_valid, tx_ready, acc, last;
  assign acc = tx_valid & tx_ready;
  assign last = ram_addr == ADDR_W'(WORDS - 1);
  always_ff @(posedge pixclk)
    state <= reset ? IDLE : state_nx;
  // FETCH/LATCH run while the previous byte is still shifting out, keeping the line gap short
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? HDR0 : IDLE;
      HDR0:  state_nx = acc ? HDR1 : HDR0;
      HDR1:  state_nx = acc ? FETCH : HDR1;
      FETCH: state_nx = LATCH;
      LATCH: state_nx = SEND;
      SEND:  state_nx = acc && byte_idx == 2'd3 ? (last ? CKSUM : FETCH) : SEND;
      CKSUM: state_nx = acc ? FIN : CKSUM;
      FIN:   state_nx = tx_ready ? IDLE : FIN;
    endcase
  end
  always_comb begin
    tx_valid = state inside {HDR0, HDR1, SEND, CKSUM};
    tx_data = state == HDR0 ? HDR0_BYTE :
              state == HDR1 ? HDR1_BYTE :
              state == CKSUM ? cksum : word[{byte_idx, 3'b000} +: 8];
    busy = state != IDLE;
    done = state == FIN && tx_ready;
  end
  // the address advances on the last byte of a word so FETCH presents the next one
  always_ff @(posedge pixclk)
    if (reset) begin
      ram_addr <= '0;
      word <= '0;
      byte_idx <= '0;
      cksum <= '0;
    end else begin
      if (state == IDLE && start) begin
        ram_addr <= '0;
        cksum <= '0;
      end
      if (state == LATCH) begin
        word <= ram_data;
        byte_idx <= '0;
      end
      if (state == SEND && acc) begin
        byte_idx <= byte_idx + 2'd1;
        cksum <= cksum + tx_data;
        if (byte_idx == 2'd3 && !last) ram_addr <= ram_addr + 1'b1;
      end
    end
  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .pixclk(pixclk),
    .reset(reset),
    .data(tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .tx(tx)
  );
endmodule

// File: tb/tb_frame_uart_dump.sv
// tb_frame_uart_dump: scoreboard bench decoding the UART line against expected frames
module tb_frame_uart_dump;
  localparam int CPB = 4;
  localparam int WORDS = 2;
  localparam int ADDR_W = 17;
  logic pixclk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0] ram_data;
  logic tx, busy, done;
  logic [31:0] mem [2];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int frame_pos = 0;
  int done_cnt = 0;
  bit addr_bad = 1'b0;

  frame_uart_dump #(.CLKS_PER_BIT(CPB), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .pixclk(pixclk),
    .reset(reset),
    .start(start),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 pixclk = ~pixclk;

  always @(posedge pixclk) begin
    cyc <= cyc + 1;
    ram_data <= mem[ram_addr[0]];
  end

  always @(negedge pixclk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (!reset && ram_addr[ADDR_W-1:1] != '0) addr_bad <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // UART decoder: samples every cycle of every bit, so a stretched or shortened bit shows up
  initial begin
    logic [9:0] v;
    bit stable, aborted;
    int last_end, t_start;
    last_end = 0;
    forever begin
      @(negedge pixclk);
      if (reset || tx !== 1'b0) continue;
      t_start = cyc;
      stable = 1'b1;
      aborted = 1'b0;
      v = '0;
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge pixclk);
          if (reset) aborted = 1'b1;
          if (c == 0) v[b] = tx;
          else if (tx !== v[b]) stable = 1'b0;
        end
      if (aborted) continue;
      if (frame_pos > 0) check("gap", 32'(t_start - last_end - 1 <= 3), 32'd1);
      last_end = cyc;
      check("start_bit", 32'(v[0]), 32'd0);
      check("stop_bit", 32'(v[9]), 32'd1);
      check("bit_time", 32'(stable), 32'd1);
      check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check($sformatf("byte%0d", frame_pos), 32'(v[8:1]), 32'(exp_q.pop_front()));
      frame_pos++;
    end
  end

  task automatic prep(input logic [31:0] w0, input logic [31:0] w1);
    logic [7:0] sum, b;
    logic [31:0] w;
    mem[0] = w0;
    mem[1] = w1;
    exp_q = {};
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    sum = 8'd0;
    for (int i = 0; i < 8; i++) begin
      w = i < 4 ? w0 : w1;
      b = w[(i % 4) * 8 +: 8];
      exp_q.push_back(b);
      sum += b;
    end
    exp_q.push_back(sum);
    frame_pos = 0;
    addr_bad = 1'b0;
  endtask

  task automatic kick();
    @(posedge pixclk);
    #1 start = 1'b1;
    @(posedge pixclk);
    #1 start = 1'b0;
    check("busy_on", 32'(busy), 32'd1);
  endtask

  task automatic run_frame(input logic [31:0] w0, input logic [31:0] w1, input bit restart);
    int d0;
    bit seen;
    prep(w0, w1);
    d0 = done_cnt;
    kick();
    seen = 1'b0;
    for (int i = 0; i < 11 * 40 + 30 && !seen; i++) begin
      @(negedge pixclk);
      if (restart && i == 150) start = 1'b1;
      if (restart && i == 151) start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        if (restart) start = 1'b1;
      end
    end
    check("done_in_time", 32'(seen), 32'd1);
    if (restart) begin
      @(posedge pixclk);
      #1 start = 1'b0;
    end
    repeat (20) @(negedge pixclk);
    check("busy_off", 32'(busy), 32'd0);
    check("tx_idle", 32'(tx), 32'd1);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("bytes_left", 32'(exp_q.size()), 32'd0);
    check("bytes_sent", 32'(frame_pos), 32'd11);
    check("addr_range", 32'(addr_bad), 32'd0);
    check("addr_final", 32'(ram_addr), 32'd1);
  endtask

  initial begin
    int lows;
    mem[0] = '0;
    mem[1] = '0;
    repeat (4) @(posedge pixclk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    reset = 1'b0;
    run_frame(32'h04030201, 32'h08070605, 1'b0);
    run_frame(32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_frame(32'h11223344, 32'hA0B0C0D0, 1'b1);
    prep(32'h04030201, 32'h08070605);
    kick();
    for (int i = 0; i < 400 && frame_pos < 5; i++) @(negedge pixclk);
    check("reached_byte5", 32'(frame_pos >= 5), 32'd1);
    repeat (3 * CPB) @(negedge pixclk);
    @(posedge pixclk);
    #1 reset = 1'b1;
    @(posedge pixclk);
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_addr", 32'(ram_addr), 32'd0);
    reset = 1'b0;
    exp_q = {};
    lows = 0;
    repeat (60) begin
      @(negedge pixclk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("post_rst_quiet", 32'(lows), 32'd0);
    run_frame(32'h04030201, 32'h08070605, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/frame_uart_dump.md
FRAME_UART_DUMP -- requirements
Module: frame_uart_dump

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning pixclk cycles per UART bit (25 MHz / 115200 baud).
REQ-002 SHALL have parameter WORDS, default 76800, meaning 32-bit framebuffer words per frame (640x480 8-bit pixels, 4 per word).
REQ-003 SHALL have parameter ADDR_W, default 17, meaning framebuffer word-address width.
REQ-004 SHALL have port pixclk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, meaning a request for one frame dump, sampled only in IDLE.
REQ-007 SHALL have port ram_addr, output, ADDR_W, meaning the framebuffer read-port word address.
REQ-008 SHALL have port ram_data, input, 32, meaning the read data, valid exactly 1 cycle after ram_addr is presented.
REQ-009 SHALL have port tx, output, 1, meaning the UART 8N1 serial line, idle high.
REQ-010 SHALL have port busy, output, 1, meaning high from the cycle after start is accepted until done.
REQ-011 SHALL have port done, output, 1, meaning a one-cycle pulse after the last stop bit of a frame.

Function
REQ-012 SHALL send each frame as: header bytes 0xA5, 0x5A; then 4*WORDS pixel bytes; then one checksum byte.
REQ-013 SHALL send pixel bytes in ascending word address from 0 to WORDS-1, each word in byte order [7:0], [15:8], [23:16], [31:24].
REQ-014 SHALL compute the checksum as the 8-bit modulo-256 sum of all pixel bytes, excluding header bytes.
REQ-015 SHALL use FSM states IDLE, HDR0, HDR1, FETCH, LATCH, SEND, CKSUM, FIN.
- IDLE->HDR0 on start=1.
- HDR0->HDR1->FETCH, each transition on serializer acceptance.
- FETCH drives ram_addr for 1 cycle, then goes to LATCH.
- LATCH registers ram_data into a 32-bit word buffer, then goes to SEND.
- SEND hands 4 bytes to the serializer, then: FETCH if address < WORDS-1, else CKSUM.
- CKSUM->FIN on acceptance.
- FIN waits for the serializer to go idle, pulses done, then returns to IDLE.
REQ-016 SHALL use a serializer handshake of byte valid/ready; a byte is accepted in the cycle both are high; valid SHALL hold with stable data until accepted.
REQ-017 SHALL make the serializer ready only when idle; each byte takes exactly 10*CLKS_PER_BIT cycles: start bit 0, data LSB first, stop bit 1.
REQ-018 SHALL keep the gap between consecutive stop and start bits at ≤3 cycles, including across word fetches (the fetch overlaps the previous byte).
REQ-019 SHALL ignore start while busy; start in the same cycle as done SHALL be ignored.
REQ-020 SHALL hold ram_addr at its last value outside FETCH; the address counter SHALL NOT wrap within a frame and SHALL reset to 0 at each new frame.
REQ-021 SHALL hold the checksum accumulator at 8 bits, wrap silently, and clear it on start acceptance.

Reset
REQ-022 SHALL, on reset=1 at any clock edge (including mid-byte), force: state IDLE, tx=1, busy=0, done=0, ram_addr=0, checksum=0, serializer idle with bit counter 0.
REQ-023 SHALL emit no partial-byte continuation after reset; tx stays high until the next start.

Structure
REQ-024 SHALL place constants HDR0_BYTE=0xA5, HDR1_BYTE=0x5A and the FSM state enumeration in shared package frame_dump_pkg.
REQ-025 SHALL implement the serializer as sub-module uart_tx_8n1 (parameter CLKS_PER_BIT; ports pixclk, reset, data[7:0], valid, ready, tx).
REQ-026 SHALL contain no RAM; the framebuffer read port is external.

Verification
Bench parameters: CLKS_PER_BIT=4, WORDS=2, RAM model with 1-cycle latency.
REQ-027 SHALL cover a basic dump: RAM {0x04030201, 0x08070605}, start pulse -> UART decoder sees A5 5A 01 02 03 04 05 06 07 08 24, then done pulse; total ≤ 11*40+30 cycles.
REQ-028 SHALL cover checksum wrap: RAM {0xFFFFFFFF, 0x00000001} -> pixel bytes FF FF FF FF 01 00 00 00, checksum 0xFD.
REQ-029 SHALL cover start while busy: start re-pulsed during a pixel byte -> exactly one frame of 11 bytes, one done.
REQ-030 SHALL cover reset mid-operation: reset asserted during byte 5 data bits -> next cycle tx=1, busy=0; a new start then produces a complete correct frame.
REQ-031 SHALL cover bit timing: each bit measured at exactly 4 cycles, stop bit high, inter-byte gap ≤3 cycles, ram_addr sequence 0,1 only.
